// File: rtl/control_unit_sequencer.sv
// Multicycle control sequencer for the MUSA core: walks each instruction through
// IF/ID/EX/MEM/WB, drives a registered control word, halt state and retire counter.
module control_unit_sequencer #(
  parameter int unsigned OPCODE_W = 6,
  parameter int unsigned FUNCT_W  = 6,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic                fetch_ack,
  input  logic                mem_ready,
  input  logic                alu_flag,
  output logic                fetch_req,
  output logic [2:0]          stage,
  output logic                read_reg,
  output logic                write_reg,
  output logic                mem_read,
  output logic                mem_write,
  output logic                immediat,
  output logic [FUNCT_W-1:0]  alu_fn,
  output logic                control_function,
  output logic                control_alu_data,
  output logic [2:0]          pc_src,
  output logic                push,
  output logic                pop,
  output logic                write_pc,
  output logic                halted,
  output logic                illegal_op,
  output logic [CNT_W-1:0]    retired
);

  localparam logic [2:0] S_IF   = 3'b000;
  localparam logic [2:0] S_ID   = 3'b001;
  localparam logic [2:0] S_EX   = 3'b010;
  localparam logic [2:0] S_MEM  = 3'b011;
  localparam logic [2:0] S_WB   = 3'b100;
  localparam logic [2:0] S_HALT = 3'b111;

  localparam logic [FUNCT_W-1:0] FN_ADD  = FUNCT_W'(6'b100000);
  localparam logic [FUNCT_W-1:0] FN_SUB  = FUNCT_W'(6'b100010);
  localparam logic [FUNCT_W-1:0] FN_AND  = FUNCT_W'(6'b100100);
  localparam logic [FUNCT_W-1:0] FN_OR   = FUNCT_W'(6'b100101);
  localparam logic [FUNCT_W-1:0] FN_FLAG = FUNCT_W'(6'b111111);

  typedef enum logic [3:0] {
    C_RTYPE, C_ADDI, C_SUBI, C_ANDI, C_ORI, C_LW, C_SW, C_JR,
    C_JPC, C_BRFL, C_HALT, C_NOP, C_CALL, C_RET, C_ILL
  } cls_e;

  // Opcodes with any bit set above the 6-bit field are illegal.
  function automatic cls_e decode(input logic [OPCODE_W-1:0] op);
    cls_e c;
    c = C_ILL;
    if ((op >> 6) == '0) begin
      case (op[5:0])
        6'b000000: c = C_RTYPE;
        6'b001000: c = C_ADDI;
        6'b001110: c = C_SUBI;
        6'b001100: c = C_ANDI;
        6'b001101: c = C_ORI;
        6'b100011: c = C_LW;
        6'b101011: c = C_SW;
        6'b011000: c = C_JR;
        6'b001001: c = C_JPC;
        6'b010001: c = C_BRFL;
        6'b000010: c = C_HALT;
        6'b000001: c = C_NOP;
        6'b000011: c = C_CALL;
        6'b000111: c = C_RET;
        default:   c = C_ILL;
      endcase
    end
    return c;
  endfunction

  function automatic logic ends_in_ex(input cls_e c);
    return c inside {C_JR, C_JPC, C_BRFL, C_NOP, C_CALL, C_RET, C_ILL};
  endfunction

  logic [2:0]         state_q, state_d;
  cls_e               cls_q, cls_d;
  logic [FUNCT_W-1:0] funct_q, funct_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               fetch_req_q, fetch_req_d, read_reg_q, read_reg_d;
  logic               write_reg_q, write_reg_d, mem_read_q, mem_read_d;
  logic               mem_write_q, mem_write_d, immediat_q, immediat_d;
  logic [FUNCT_W-1:0] alu_fn_q, alu_fn_d;
  logic               ctl_fn_q, ctl_fn_d, ctl_alu_data_q, ctl_alu_data_d;
  logic [2:0]         pc_src_q, pc_src_d;
  logic               push_q, push_d, pop_q, pop_d, write_pc_q, write_pc_d;
  logic               halted_q, halted_d, illegal_q, illegal_d;
  logic               sw_commit_c, commit_c;

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IF;
      cls_q          <= C_NOP;
      funct_q        <= '0;
      retired_q      <= '0;
      fetch_req_q    <= 1'b0;
      read_reg_q     <= 1'b0;
      write_reg_q    <= 1'b0;
      mem_read_q     <= 1'b0;
      mem_write_q    <= 1'b0;
      immediat_q     <= 1'b0;
      alu_fn_q       <= '0;
      ctl_fn_q       <= 1'b0;
      ctl_alu_data_q <= 1'b0;
      pc_src_q       <= '0;
      push_q         <= 1'b0;
      pop_q          <= 1'b0;
      write_pc_q     <= 1'b0;
      halted_q       <= 1'b0;
      illegal_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cls_q          <= cls_d;
      funct_q        <= funct_d;
      retired_q      <= retired_d;
      fetch_req_q    <= fetch_req_d;
      read_reg_q     <= read_reg_d;
      write_reg_q    <= write_reg_d;
      mem_read_q     <= mem_read_d;
      mem_write_q    <= mem_write_d;
      immediat_q     <= immediat_d;
      alu_fn_q       <= alu_fn_d;
      ctl_fn_q       <= ctl_fn_d;
      ctl_alu_data_q <= ctl_alu_data_d;
      pc_src_q       <= pc_src_d;
      push_q         <= push_d;
      pop_q          <= pop_d;
      write_pc_q     <= write_pc_d;
      halted_q       <= halted_d;
      illegal_q      <= illegal_d;
    end
  end

  // Next-state logic; opcode/funct are captured on the accepted fetch.
  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    funct_d = funct_q;
    case (state_q)
      S_IF: if (fetch_ack) begin
        state_d = S_ID;
        cls_d   = decode(opcode);
        funct_d = funct;
      end
      S_ID: state_d = S_EX;
      S_EX: begin
        if (cls_q inside {C_LW, C_SW})                            state_d = S_MEM;
        else if (cls_q inside {C_RTYPE, C_ADDI, C_SUBI, C_ANDI, C_ORI}) state_d = S_WB;
        else if (cls_q == C_HALT)                                 state_d = S_HALT;
        else                                                      state_d = S_IF;
      end
      S_MEM:   if (mem_ready) state_d = (cls_q == C_LW) ? S_WB : S_IF;
      S_WB:    state_d = S_IF;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IF;
    endcase
  end

  // A store finishes in the MEM cycle that sees mem_ready, so its commit cannot be registered.
  assign sw_commit_c = (state_q == S_MEM) && (cls_q == C_SW) && mem_ready;
  assign commit_c    = write_pc_q || sw_commit_c;
  assign retired_d   = commit_c ? retired_q + CNT_W'(1) : retired_q;

  // Output decode for the cycle being entered.
  always_comb begin
    fetch_req_d    = (state_d == S_IF);
    halted_d       = (state_d == S_HALT);
    illegal_d      = (state_q == S_IF) && fetch_ack && (cls_d == C_ILL);
    read_reg_d     = 1'b0;
    write_reg_d    = 1'b0;
    mem_read_d     = 1'b0;
    mem_write_d    = 1'b0;
    immediat_d     = 1'b0;
    alu_fn_d       = '0;
    ctl_fn_d       = 1'b0;
    ctl_alu_data_d = 1'b0;
    pc_src_d       = 3'b000;
    push_d         = 1'b0;
    pop_d          = 1'b0;
    write_pc_d     = 1'b0;
    if (state_d inside {S_EX, S_MEM, S_WB}) begin
      case (cls_q)
        C_RTYPE: begin read_reg_d = 1'b1; alu_fn_d = funct_q; end
        C_ADDI:  begin read_reg_d = 1'b1; immediat_d = 1'b1; alu_fn_d = FN_ADD; ctl_fn_d = 1'b1; end
        C_SUBI:  begin read_reg_d = 1'b1; immediat_d = 1'b1; alu_fn_d = FN_SUB; ctl_fn_d = 1'b1; end
        C_ANDI:  begin read_reg_d = 1'b1; immediat_d = 1'b1; alu_fn_d = FN_AND; ctl_fn_d = 1'b1; end
        C_ORI:   begin read_reg_d = 1'b1; immediat_d = 1'b1; alu_fn_d = FN_OR;  ctl_fn_d = 1'b1; end
        C_LW: begin
          read_reg_d = 1'b1; immediat_d = 1'b1; alu_fn_d = FN_ADD; ctl_fn_d = 1'b1;
          ctl_alu_data_d = 1'b1;
        end
        C_SW:    begin read_reg_d = 1'b1; immediat_d = 1'b1; alu_fn_d = FN_ADD; ctl_fn_d = 1'b1; end
        C_JR:    read_reg_d = 1'b1;
        C_JPC:   immediat_d = 1'b1;
        C_BRFL:  begin read_reg_d = 1'b1; alu_fn_d = FN_FLAG; ctl_fn_d = 1'b1; end
        default: ;
      endcase
    end
    if (state_d == S_EX) begin
      case (cls_q)
        C_CALL:  begin push_d = 1'b1; pc_src_d = 3'b010; end
        C_RET:   begin pop_d = 1'b1; pc_src_d = 3'b101; end
        C_JR:    pc_src_d = 3'b001;
        C_JPC:   pc_src_d = 3'b100;
        C_BRFL:  pc_src_d = alu_flag ? 3'b110 : 3'b000;
        default: ;
      endcase
      write_pc_d = ends_in_ex(cls_q);
    end
    if (state_d == S_MEM) begin
      mem_read_d  = (cls_q == C_LW);
      mem_write_d = (cls_q == C_SW);
    end
    if (state_d == S_WB) begin
      write_reg_d = 1'b1;
      write_pc_d  = 1'b1;
    end
  end

  assign fetch_req        = fetch_req_q;
  assign stage            = state_q;
  assign read_reg         = read_reg_q;
  assign write_reg        = write_reg_q;
  assign mem_read         = mem_read_q;
  assign mem_write        = mem_write_q;
  assign immediat         = immediat_q;
  assign alu_fn           = alu_fn_q;
  assign control_function = ctl_fn_q;
  assign control_alu_data = ctl_alu_data_q;
  assign pc_src           = pc_src_q;
  assign push             = push_q;
  assign pop              = pop_q;
  assign write_pc         = write_pc_q || sw_commit_c;
  assign halted           = halted_q;
  assign illegal_op       = illegal_q;
  assign retired          = retired_q;

endmodule

// File: tb/tb_control_unit_sequencer.sv
// Scoreboard bench for control_unit_sequencer: expected per-cycle output words are
// queued as each instruction is driven and compared on the falling edge.
module tb_control_unit_sequencer;

  localparam int unsigned OW = 6;
  localparam int unsigned FW = 6;
  localparam int unsigned CW = 4;

  localparam logic [2:0] S_IF   = 3'b000;
  localparam logic [2:0] S_ID   = 3'b001;
  localparam logic [2:0] S_EX   = 3'b010;
  localparam logic [2:0] S_MEM  = 3'b011;
  localparam logic [2:0] S_WB   = 3'b100;
  localparam logic [2:0] S_HALT = 3'b111;

  typedef struct packed {
    logic [2:0]    stage;
    logic          fr, rr, wr, mr, mw, imm;
    logic [FW-1:0] fn;
    logic          cf, cad;
    logic [2:0]    pcs;
    logic          psh, pp, wpc, hlt, ill;
    logic [CW-1:0] ret;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [OW-1:0] opcode = '0;
  logic [FW-1:0] funct = '0;
  logic          fetch_ack = 1'b0, mem_ready = 1'b0, alu_flag = 1'b0;
  logic          fetch_req, read_reg, write_reg, mem_read, mem_write, immediat;
  logic [2:0]    stage, pc_src;
  logic [FW-1:0] alu_fn;
  logic          control_function, control_alu_data, push, pop, write_pc, halted, illegal_op;
  logic [CW-1:0] retired;

  always #5 clk = ~clk;

  control_unit_sequencer #(.OPCODE_W(OW), .FUNCT_W(FW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .fetch_ack(fetch_ack),
    .mem_ready(mem_ready), .alu_flag(alu_flag), .fetch_req(fetch_req), .stage(stage),
    .read_reg(read_reg), .write_reg(write_reg), .mem_read(mem_read), .mem_write(mem_write),
    .immediat(immediat), .alu_fn(alu_fn), .control_function(control_function),
    .control_alu_data(control_alu_data), .pc_src(pc_src), .push(push), .pop(pop),
    .write_pc(write_pc), .halted(halted), .illegal_op(illegal_op), .retired(retired)
  );

  exp_t obs;
  assign obs = {stage, fetch_req, read_reg, write_reg, mem_read, mem_write, immediat, alu_fn,
                control_function, control_alu_data, pc_src, push, pop, write_pc, halted,
                illegal_op, retired};

  int            n_cmp = 0;
  int            n_bad = 0;
  exp_t          exp_q[$];
  string         tag_q[$];
  logic [CW-1:0] ret_m = '0;

  task automatic check_eq(input string tag, input exp_t got, input exp_t want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) check_eq(tag_q.pop_front(), obs, exp_q.pop_front());
  end

  task automatic sb_push(input string tag, input exp_t e);
    tag_q.push_back(tag);
    exp_q.push_back(e);
  endtask

  function automatic exp_t idle(input logic [2:0] st);
    exp_t e;
    e       = '0;
    e.stage = st;
    e.fr    = (st == S_IF);
    e.hlt   = (st == S_HALT);
    e.ret   = ret_m;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset: outputs must clear at once, without a clock edge.
  task automatic reset_seq(input string tag);
    reset     = 1'b1;
    fetch_ack = 1'b0;
    mem_ready = 1'b0;
    #1;
    check_eq(tag, obs, '0);
    @(negedge clk);
    check_eq({tag, " hold"}, obs, '0);
    reset = 1'b0;
    ret_m = '0;
  endtask

  task automatic run_instr(input string nm, input logic [5:0] op, input logic [5:0] fn,
                           input logic flag, input int fwait, input int mwait, input bit abort);
    exp_t       cw, e;
    logic [2:0] pcs;
    logic       psh, pp, ill, exc, is_mem, is_wb, is_lw;
    cw = '0; pcs = 3'b000; psh = 0; pp = 0; ill = 0; exc = 0; is_mem = 0; is_wb = 0;
    is_lw = (op == 6'b100011);
    case (op)
      6'b000000: begin cw.rr = 1; cw.fn = fn; is_wb = 1; end
      6'b001000: begin cw.rr = 1; cw.imm = 1; cw.fn = 6'b100000; cw.cf = 1; is_wb = 1; end
      6'b001110: begin cw.rr = 1; cw.imm = 1; cw.fn = 6'b100010; cw.cf = 1; is_wb = 1; end
      6'b001100: begin cw.rr = 1; cw.imm = 1; cw.fn = 6'b100100; cw.cf = 1; is_wb = 1; end
      6'b001101: begin cw.rr = 1; cw.imm = 1; cw.fn = 6'b100101; cw.cf = 1; is_wb = 1; end
      6'b100011: begin
        cw.rr = 1; cw.imm = 1; cw.fn = 6'b100000; cw.cf = 1; cw.cad = 1; is_mem = 1; is_wb = 1;
      end
      6'b101011: begin cw.rr = 1; cw.imm = 1; cw.fn = 6'b100000; cw.cf = 1; is_mem = 1; end
      6'b011000: begin cw.rr = 1; pcs = 3'b001; exc = 1; end
      6'b001001: begin cw.imm = 1; pcs = 3'b100; exc = 1; end
      6'b010001: begin cw.rr = 1; cw.fn = 6'b111111; cw.cf = 1; pcs = flag ? 3'b110 : 3'b000; exc = 1; end
      6'b000010: ;
      6'b000001: exc = 1;
      6'b000011: begin psh = 1; pcs = 3'b010; exc = 1; end
      6'b000111: begin pp = 1; pcs = 3'b101; exc = 1; end
      default:   begin ill = 1; exc = 1; end
    endcase
    for (int i = 0; i < fwait; i++) begin
      tick(); fetch_ack = 1'b0; opcode = 6'($urandom);
      sb_push({nm, " IF wait"}, idle(S_IF));
    end
    tick(); fetch_ack = 1'b1; opcode = op; funct = fn; alu_flag = flag; mem_ready = 1'b0;
    sb_push({nm, " IF"}, idle(S_IF));
    tick(); fetch_ack = 1'($urandom);
    e = idle(S_ID); e.ill = ill;
    sb_push({nm, " ID"}, e);
    tick(); fetch_ack = 1'b0;
    e = exp_t'(idle(S_EX) | cw); e.pcs = pcs; e.psh = psh; e.pp = pp; e.wpc = exc;
    sb_push({nm, " EX"}, e);
    if (exc) ret_m = ret_m + 1'b1;
    if (is_mem) begin
      for (int i = 0; i < mwait; i++) begin
        tick(); mem_ready = 1'b0;
        e = exp_t'(idle(S_MEM) | cw); e.mr = is_lw; e.mw = !is_lw;
        sb_push({nm, " MEM stall"}, e);
      end
      if (abort) begin
        tick();
        reset_seq({nm, " abort"});
        return;
      end
      tick(); mem_ready = 1'b1;
      e = exp_t'(idle(S_MEM) | cw); e.mr = is_lw; e.mw = !is_lw; e.wpc = !is_lw;
      sb_push({nm, " MEM done"}, e);
      if (!is_lw) ret_m = ret_m + 1'b1;
    end
    if (is_wb) begin
      tick(); mem_ready = 1'b0;
      e = exp_t'(idle(S_WB) | cw); e.wr = 1; e.wpc = 1;
      sb_push({nm, " WB"}, e);
      ret_m = ret_m + 1'b1;
    end
  endtask

  initial begin
    #1;
    reset_seq("rst init");
    run_instr("addi",   6'b001000, 6'b000000, 1'b0, 0, 0, 0);
    run_instr("rtype",  6'b000000, 6'b100110, 1'b0, 2, 0, 0);
    run_instr("subi",   6'b001110, 6'b010101, 1'b0, 0, 0, 0);
    run_instr("andi",   6'b001100, 6'b000000, 1'b0, 1, 0, 0);
    run_instr("ori",    6'b001101, 6'b000000, 1'b0, 0, 0, 0);
    run_instr("lw",     6'b100011, 6'b000000, 1'b0, 0, 3, 0);
    run_instr("sw",     6'b101011, 6'b000000, 1'b0, 0, 0, 0);
    run_instr("sw slow",6'b101011, 6'b000000, 1'b0, 0, 2, 0);
    run_instr("lw fast",6'b100011, 6'b000000, 1'b0, 0, 0, 0);
    run_instr("brfl t", 6'b010001, 6'b000000, 1'b1, 0, 0, 0);
    run_instr("brfl nt",6'b010001, 6'b000000, 1'b0, 0, 0, 0);
    run_instr("jr",     6'b011000, 6'b000000, 1'b0, 0, 0, 0);
    run_instr("jpc",    6'b001001, 6'b000000, 1'b0, 0, 0, 0);
    run_instr("call",   6'b000011, 6'b000000, 1'b0, 0, 0, 0);
    run_instr("ret",    6'b000111, 6'b000000, 1'b0, 0, 0, 0);
    run_instr("nop",    6'b000001, 6'b000000, 1'b0, 0, 0, 0);
    run_instr("illegal",6'b111110, 6'b000000, 1'b0, 0, 0, 0);
    run_instr("halt",   6'b000010, 6'b000000, 1'b0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      tick(); fetch_ack = i[0]; opcode = 6'b001000;
      sb_push("halt hold", idle(S_HALT));
    end
    tick();
    reset_seq("rst halt");
    run_instr("lw abort", 6'b100011, 6'b000000, 1'b0, 0, 2, 1);
    run_instr("addi post",6'b001000, 6'b000000, 1'b0, 0, 0, 0);
    for (int i = 0; i < 17; i++) run_instr("nop wrap", 6'b000001, 6'b000000, 1'b0, 0, 0, 0);
    tick();
    sb_push("final IF", idle(S_IF));
    @(negedge clk);
    #1;
    check_eq("drain", exp_t'(exp_q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/control_unit_sequencer.md
Name: control_unit_sequencer

Overview:
Parametrised multicycle control unit for the MUSA core.
- Sequences each instruction through IF/ID/EX/MEM/WB with an explicit state machine.
- Skips stages the opcode does not need.
- Stalls on instruction-fetch and data-memory handshakes.
- Drives the datapath with a registered control word, plus a halt state, illegal-opcode flag and retired-instruction counter.

Parameters:
OPCODE_W, 6, opcode field width
FUNCT_W, 6, ALU function field width (R-type funct passthrough and immediate ALU codes)
CNT_W, 16, width of retired-instruction counter

Ports:
clk  in  1  clock, all state changes on rising edge
reset  in  1  asynchronous, active-high reset
opcode  in  OPCODE_W  opcode of fetched instruction, sampled when fetch_ack=1 in IF
funct  in  FUNCT_W  funct field, sampled with opcode
fetch_ack  in  1  instruction memory has valid instruction
mem_ready  in  1  data memory completes access this cycle
alu_flag  in  1  ALU flag used by brfl
fetch_req  out  1  request instruction (high throughout IF)
stage  out  3  IF=000 ID=001 EX=010 MEM=011 WB=100 HALT=111
read_reg  out  1  register-file read enable
write_reg  out  1  register-file write strobe
mem_read  out  1  data-memory read request
mem_write  out  1  data-memory write request
immediat  out  1  select immediate operand
alu_fn  out  FUNCT_W  ALU function code
control_function  out  1  1: use alu_fn from this block; 0: use instruction funct
control_alu_data  out  1  write-back source: 1 memory, 0 ALU
pc_src  out  3  000 seq, 001 jr, 010 call, 100 jpc, 101 ret, 110 brfl taken
push  out  1  return-stack push strobe
pop  out  1  return-stack pop strobe
write_pc  out  1  PC update strobe (instruction commit)
halted  out  1  in HALT
illegal_op  out  1  one-cycle pulse, unknown opcode
retired  out  CNT_W  committed-instruction count

Behaviour:
- Reset (async): state IF; every output 0 (stage=000, retired=0). Reset mid-instruction aborts it with no commit strobes.
- Opcodes:
  - r_type=000000
  - addi=001000, subi=001110, andi=001100, ori=001101
  - lw=100011, sw=101011
  - jr=011000, jpc=001001, brfl=010001, halt=000010, nop=000001, call=000011, ret=000111
  - Compare at OPCODE_W using the low 6 bits; upper bits must be 0, otherwise the opcode is illegal.
- Outputs are registered; control word decoded in ID and held stable from EX until leaving the instruction.
- Alu_fn values:
  - r_type: alu_fn=funct, control_function=0.
  - addi, lw, sw: alu_fn=100000, control_function=1.
  - subi: alu_fn=100010, control_function=1.
  - andi: alu_fn=100100, control_function=1.
  - ori: alu_fn=100101, control_function=1.
  - brfl: alu_fn=111111, control_function=1.
- Other control fields:
  - immediat=1 for addi/subi/andi/ori/lw/sw/jpc.
  - read_reg=1 for r_type, immediate ops, lw, sw, jr, brfl.
  - control_alu_data=1 for lw.
- IF: fetch_req=1. On fetch_ack=1, latch opcode/funct and go to ID; otherwise stay in IF indefinitely.
- ID: one cycle; load control word.
  - Illegal opcode: pulse illegal_op, treat as nop.
- EX: one cycle.
  - call: push=1, pc_src=010.
  - ret: pop=1, pc_src=101.
  - jr: pc_src=001. jpc: pc_src=100.
  - brfl: pc_src=110 if alu_flag=1 else 000.
  - Next state:
    - lw/sw: MEM.
    - r_type/immediate: WB.
    - jr/jpc/call/ret/brfl/nop/illegal: commit, then IF.
    - halt: HALT with no commit.
- MEM: mem_read (lw) or mem_write (sw) held high while mem_ready=0.
  - On mem_ready=1: sw commits and goes to IF; lw goes to WB.
- WB: one cycle, write_reg=1, commit, then IF.
- Commit:
  - write_pc=1 for exactly one cycle, in the final cycle of the instruction.
  - retired increments by 1 in the same edge; wraps at 2^CNT_W-1 to 0.
- Strobe timing:
  - push/pop last exactly one cycle.
  - write_reg, mem_read, mem_write are never high outside their stage.
  - Leaving to IF clears the whole control word to 0.
- HALT: halted=1, stage=111, all other strobes 0. Only reset exits; fetch_ack is ignored.
- Latencies with fetch_ack and mem_ready immediate:
  - r_type/immediate: 4 cycles.
  - sw: 4 cycles.
  - lw: 5 cycles.
  - jumps/nop: 3 cycles.

Test Plan:
- Reset, then addi with fetch_ack high → stage 000,001,010,100; immediat=1, alu_fn=100000; write_reg and write_pc high only in cycle 4; retired=1.
- lw with mem_ready low for 3 cycles → mem_read high 4 cycles; stage held at 011; then WB with control_alu_data=1; total 8 cycles.
- brfl with alu_flag=1 and then with alu_flag=0 → pc_src=110 vs 000; write_pc pulse in EX; write_reg never high.
- call then ret → push for 1 cycle (pc_src=010); pop for 1 cycle (pc_src=101); retired=2.
- Opcode 111110 → illegal_op 1-cycle pulse in ID, commits as nop; halt → halted=1, stays with fetch_ack toggling; retired unchanged.
- Reset asserted during MEM stall → outputs 0 immediately (asynchronous); after release, IF with fetch_req=1; retired=0.
